// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder response checker.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 4;

  // Number of distinct {a,b} operand pairs for a given operand width.
  function automatic int combo_count(input int width);
    return 1 << (2 * width);
  endfunction

endpackage

// File: rtl/combo_cov_map.sv
// Seen-map of operand combinations; reports when every combination has been observed.
module combo_cov_map #(
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_set,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_full,
  output logic             o_fill_now
);

  localparam int N = 1 << IDX_W;

  logic [N-1:0] r_map;
  logic [N-1:0] w_map_next;

  always_comb begin
    w_map_next = r_map;
    if (i_set) w_map_next[i_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_clear) r_map <= '0;
    else         r_map <= w_map_next;
  end

  assign o_full     = &r_map;
  // High on the set that makes the map complete, so the FSM can leave RUN on that edge.
  assign o_fill_now = i_set && !o_full && (&w_map_next);

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for adder DUTs: counts pass/fail, captures the first failure, flags completion.
// Optional macro COMBO_COVERAGE_EN: completion on full operand-pair coverage instead of sample count.
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_sum,
  output logic             ff_carry,
  output logic             done,
`ifdef COMBO_COVERAGE_EN
  output logic             cov_full,
`endif
  output state_t           dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready is combinational from state and clear, in_valid without in_ready drops the sample.

  localparam int              N       = combo_count(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("adder_resp_checker: WIDTH out of range");
  end

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_pass, r_fail;
  logic             r_err;
  logic [WIDTH-1:0] r_ff_a, r_ff_b, r_ff_sum;
  logic             r_ff_carry;
  logic             w_accept, w_pass, w_complete;
  logic [WIDTH:0]   w_exp;

  assign in_ready = (r_state == RUN) && !clear;
  assign w_accept = in_valid && in_ready;
  assign w_exp    = {1'b0, in_a} + {1'b0, in_b};
  // Case equality makes any X/Z in the sample fail the check.
  assign w_pass   = ({in_carry, in_sum} === w_exp);

`ifdef COMBO_COVERAGE_EN
  logic w_fill_now;

  combo_cov_map #(.IDX_W(2 * WIDTH)) u_cov_map (
    .clk        (clk),
    .i_clear    (rst || clear),
    .i_set      (w_accept),
    .i_idx      ({in_a, in_b}),
    .o_full     (cov_full),
    .o_fill_now (w_fill_now)
  );

  assign w_complete = w_fill_now;
`else
  logic [31:0] w_total_next;

  assign w_total_next = 32'(r_pass) + 32'(r_fail) + 32'd1;
  assign w_complete   = w_accept && (w_total_next == 32'(N));
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_state_next = RUN;
        RUN:     if (w_complete) w_state_next = DONE;
        DONE:    w_state_next = DONE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_pass     <= '0;
      r_fail     <= '0;
      r_err      <= 1'b0;
      r_ff_a     <= '0;
      r_ff_b     <= '0;
      r_ff_sum   <= '0;
      r_ff_carry <= 1'b0;
    end else if (w_accept) begin
      if (w_pass) begin
        if (r_pass != CNT_MAX) r_pass <= r_pass + 1'b1;
      end else begin
        if (r_fail != CNT_MAX) r_fail <= r_fail + 1'b1;
        r_err <= 1'b1;
        if (!r_err) begin
          r_ff_a     <= in_a;
          r_ff_b     <= in_b;
          r_ff_sum   <= in_sum;
          r_ff_carry <= in_carry;
        end
      end
    end
  end

  assign pass_cnt  = r_pass;
  assign fail_cnt  = r_fail;
  assign err       = r_err;
  assign ff_a      = r_ff_a;
  assign ff_b      = r_ff_b;
  assign ff_sum    = r_ff_sum;
  assign ff_carry  = r_ff_carry;
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Self-checking bench for adder_resp_checker: vector tables, corner sequences, randomized runs vs a model.
`timescale 1ns/1ps
module tb_adder_resp_checker;
  import adder_chk_pkg::*;

`ifdef COMBO_COVERAGE_EN
  localparam int W = 2;
`else
  localparam int W = 1;
`endif
  localparam int CW   = 16;
  localparam int N    = 1 << (2 * W);
  localparam int CMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst, start, clear, in_valid, in_carry;
  logic [W-1:0] in_a, in_b, in_sum;
  logic         in_ready, err, ff_carry, done;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [W-1:0] ff_a, ff_b, ff_sum;
  state_t       dbg_state;
`ifdef COMBO_COVERAGE_EN
  logic         cov_full;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_resp_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_carry(in_carry),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
    .ff_a(ff_a), .ff_b(ff_b), .ff_sum(ff_sum), .ff_carry(ff_carry),
    .done(done),
`ifdef COMBO_COVERAGE_EN
    .cov_full(cov_full),
`endif
    .dbg_state(dbg_state)
  );

`ifndef COMBO_COVERAGE_EN
  // 1-bit counters: saturation is reached after a single sample.
  logic         s_ready, s_err, s_ffc, s_done;
  logic [0:0]   s_pass, s_fail;
  logic [W-1:0] s_ffa, s_ffb, s_ffs;
  state_t       s_state;

  adder_resp_checker #(.WIDTH(W), .CNT_W(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(s_ready),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_carry(in_carry),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .err(s_err),
    .ff_a(s_ffa), .ff_b(s_ffb), .ff_sum(s_ffs), .ff_carry(s_ffc),
    .done(s_done), .dbg_state(s_state)
  );
`endif

  // Reference model: run/done flags, counts and a set of seen operand pairs.
  bit           m_run, m_done, m_err, m_ffc;
  int           m_pass, m_fail;
  logic [W-1:0] m_ffa, m_ffb, m_ffs;
  bit           m_seen[int];

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_err = 0; m_pass = 0; m_fail = 0;
    m_ffa = '0; m_ffb = '0; m_ffs = '0; m_ffc = 0;
    m_seen.delete();
  endfunction

  function automatic void model_accept(input logic [W-1:0] a, b, s, input logic c);
    int  sum_exp = int'(a) + int'(b);
    bit  ok      = ((int'(c) << W) + int'(s)) == sum_exp;
    if (ok) m_pass = (m_pass < CMAX) ? m_pass + 1 : m_pass;
    else begin
      m_fail = (m_fail < CMAX) ? m_fail + 1 : m_fail;
      if (!m_err) begin m_ffa = a; m_ffb = b; m_ffs = s; m_ffc = c; end
      m_err = 1;
    end
    m_seen[(int'(a) << W) + int'(b)] = 1;
`ifdef COMBO_COVERAGE_EN
    if (m_seen.num() == N) begin m_run = 0; m_done = 1; end
`else
    if (m_pass + m_fail == N) begin m_run = 0; m_done = 1; end
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    state_t m_state = m_done ? DONE : (m_run ? RUN : IDLE);
    check({tag, " pass_cnt"}, 32'(pass_cnt), 32'(m_pass));
    check({tag, " fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
    check({tag, " err"},      32'(err),      32'(m_err));
    check({tag, " done"},     32'(done),     32'(m_done));
    check({tag, " state"},    32'(dbg_state), 32'(m_state));
    check({tag, " in_ready"}, 32'(in_ready), 32'(m_run));
    check({tag, " ff"}, 32'({ff_a, ff_b, ff_sum, ff_carry}), 32'({m_ffa, m_ffb, m_ffs, m_ffc}));
`ifdef COMBO_COVERAGE_EN
    check({tag, " cov_full"}, 32'(cov_full), 32'(m_seen.num() == N));
`endif
  endtask

  // All driver tasks start and end at a falling edge with inputs idle.
  task automatic do_reset();
    rst = 1; @(negedge clk); rst = 0; model_reset();
  endtask

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
    if (!m_run && !m_done) m_run = 1;
  endtask

  task automatic do_clear();
    clear = 1; @(negedge clk); clear = 0; model_reset();
  endtask

  task automatic send(input logic [W-1:0] a, b, s, input logic c);
    in_a = a; in_b = b; in_sum = s; in_carry = c; in_valid = 1;
    #1 check("in_ready pre", 32'(in_ready), 32'(m_run));
    @(negedge clk);
    in_valid = 0;
    if (m_run) model_accept(a, b, s, c);
  endtask

  task automatic send_good(input logic [W-1:0] a, b);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b};
    send(a, b, r[W-1:0], r[W]);
  endtask

  typedef struct {
    bit        restart;
    logic [W-1:0] a, b, s;
    logic      c;
    int        e_pass, e_fail;
    bit        e_err, e_done;
  } vec_t;

  initial begin
    rst = 0; start = 0; clear = 0; in_valid = 0;
    in_a = '0; in_b = '0; in_sum = '0; in_carry = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    check_model("reset");
    check("reset pass_cnt", 32'(pass_cnt), 32'd0);

`ifndef COMBO_COVERAGE_EN
    begin
      vec_t tbl[8];
      tbl[0] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0};
      tbl[1] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0, 0, 0};
      tbl[2] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 0, 0, 0};
      tbl[3] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 0, 0, 1};
      tbl[4] = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1, 0};
      tbl[5] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 0};
      tbl[6] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1, 1, 0};
      tbl[7] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1, 1, 1};
      for (int i = 0; i < 8; i++) begin
        if (tbl[i].restart) begin do_clear(); pulse_start(); end
        send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c);
        check($sformatf("tbl%0d pass_cnt", i), 32'(pass_cnt), 32'(tbl[i].e_pass));
        check($sformatf("tbl%0d fail_cnt", i), 32'(fail_cnt), 32'(tbl[i].e_fail));
        check($sformatf("tbl%0d err", i),      32'(err),      32'(tbl[i].e_err));
        check($sformatf("tbl%0d done", i),     32'(done),     32'(tbl[i].e_done));
        check($sformatf("tbl%0d sat pass", i), 32'(s_pass), 32'(tbl[i].e_pass > 0));
        check($sformatf("tbl%0d sat fail", i), 32'(s_fail), 32'(tbl[i].e_fail > 0));
        check_model($sformatf("tbl%0d", i));
      end
      check("T2 first fail", 32'({ff_a, ff_b, ff_sum, ff_carry}), 32'(4'b1110));
    end
`else
    // Coverage completion: 12 unique pairs plus 4 duplicates must not finish the run.
    do_clear(); pulse_start();
    for (int i = 0; i < 12; i++) send_good(W'(i >> W), W'(i));
    for (int i = 0; i < 4; i++)  send_good(W'(i >> W), W'(i));
    check("T5 done early", 32'(done), 32'd0);
    check("T5 cov early", 32'(cov_full), 32'd0);
    check("T5 pass 16", 32'(pass_cnt), 32'd16);
    check_model("T5 mid");
    for (int i = 12; i < 16; i++) send_good(W'(i >> W), W'(i));
    check("T5 done", 32'(done), 32'd1);
    check("T5 cov_full", 32'(cov_full), 32'd1);
    check_model("T5 end");
`endif

    // Samples offered in DONE are not counted.
    for (int i = 0; i < 3; i++) send_good(W'($urandom_range(0, (1 << W) - 1)), '0);
    check_model("T3 done");
    // Samples offered in IDLE are not counted.
    do_clear();
    for (int i = 0; i < 3; i++) send('1, '1, '0, 1'b1);
    check_model("T3 idle");
    check("T3 idle pass", 32'(pass_cnt), 32'd0);

    // start with clear in IDLE: clear wins.
    start = 1; clear = 1; @(negedge clk); start = 0; clear = 0; model_reset();
    check("start+clear state", 32'(dbg_state), 32'(IDLE));

    // clear together with an accepted sample: clear wins.
    pulse_start();
    send('0, '1, '1, 1'b0);
    send('1, '0, '0, 1'b0);
    check_model("T4 pre");
    in_a = '1; in_b = '1; in_sum = '0; in_carry = 1; in_valid = 1; clear = 1;
    #1 check("T4 ready", 32'(in_ready), 32'd0);
    @(negedge clk); in_valid = 0; clear = 0; model_reset();
    check("T4 state", 32'(dbg_state), 32'(IDLE));
    check("T4 pass", 32'(pass_cnt), 32'd0);
    check("T4 fail", 32'(fail_cnt), 32'd0);
    check("T4 err", 32'(err), 32'd0);
    check_model("T4");

    // Reset mid-run, with start asserted alongside: rst wins.
    pulse_start();
    send('0, '0, '1, 1'b1);
    send_good('0, '1);
    rst = 1; start = 1; @(negedge clk); rst = 0; start = 0; model_reset();
    check("T6 state", 32'(dbg_state), 32'(IDLE));
    check("T6 outputs", 32'({pass_cnt, fail_cnt, err, ff_a, ff_b, ff_sum, ff_carry, done}), 32'd0);
    check_model("T6 rst");
    pulse_start();
    for (int i = 0; i < N; i++) send_good(W'(i >> W), W'(i));
    check("T6 pass", 32'(pass_cnt), 32'(N));
    check("T6 done", 32'(done), 32'd1);

    // Randomized runs against the model.
    for (int run = 0; run < 6; run++) begin
      do_clear();
      pulse_start();
      for (int k = 0; k < 12 * N && m_run; k++) begin
        logic [W-1:0] a, b;
        a = W'($urandom_range(0, (1 << W) - 1));
        b = W'($urandom_range(0, (1 << W) - 1));
        if ($urandom_range(0, 9) < 2) begin
          in_a = a; in_b = b; @(negedge clk);
        end else if ($urandom_range(0, 3) == 0) begin
          send(a, b, W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
        end else begin
          send_good(a, b);
        end
        check_model($sformatf("rnd%0d.%0d", run, k));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
